// File: rtl/seq_umin_select.sv
//==============================================================================
// Module  : seq_umin_select
// Brief   : Multi-cycle unsigned min(a,b) selector, CHUNK bits per cycle, LSB first.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_umin_select #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_min,
    output logic         out_a_lt_b
);

    localparam int NCH  = W / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);

    generate
        if ((CHUNK < 1) || ((W % CHUNK) != 0)) begin : g_bad_chunk
            $error("seq_umin_select: W must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_min;
    logic             r_lt;
    logic             r_out_lt;
    logic [IDXW-1:0]  r_idx;
    logic [CHUNK-1:0] w_ac;
    logic [CHUNK-1:0] w_bc;
    logic             w_lt_nxt;
    logic             w_last;
    logic             w_accept;

    assign w_ac     = r_a[int'(r_idx)*CHUNK +: CHUNK];
    assign w_bc     = r_b[int'(r_idx)*CHUNK +: CHUNK];
    // Higher chunks override; equality propagates the verdict of the lower chunks.
    assign w_lt_nxt = (w_ac < w_bc) | ((w_ac == w_bc) & r_lt);
    assign w_last   = (r_idx == IDX_LAST);
    assign w_accept = in_valid & in_ready;

    assign out_min    = r_min;
    assign out_a_lt_b = r_out_lt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_CMP;
                end
            end
            ST_CMP: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_min    <= '0;
            r_lt     <= 1'b0;
            r_out_lt <= 1'b0;
            r_idx    <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_lt  <= 1'b0;
                r_idx <= '0;
            end else if (r_state == ST_CMP) begin
                r_lt <= w_lt_nxt;
                if (w_last) begin
                    r_min    <= w_lt_nxt ? r_a : r_b;
                    r_out_lt <= w_lt_nxt;
                end else begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire
